nand_tdm_demux: RTL and testbench

NAND_TDM_DEMUX -- requirements
Module: nand_tdm_demux

---
 rtl/nand_tdm_demux.sv | 125 ++++++++++++
 tb/tb_nand_tdm_demux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nand_tdm_demux.sv
// Four-slot serial TDM demultiplexer: sync-aligned capture of din into channels a..d, with lock tracking.
// Latency: a..d, frame_valid and frame_cnt update one clk after the slot-3 strobe edge.
// Backpressure: none; en is a slot strobe, and cycles with en=0 leave all state untouched.
module nand_tdm_demux (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       sync,
    input  logic       en,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       s1,
    output logic       s0,
    output logic       locked,
    output logic       frame_valid,
    output logic       sync_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_slot;
    logic        r_sh_a;
    logic        r_sh_b;
    logic        r_sh_c;
    logic        r_a;
    logic        r_b;
    logic        r_c;
    logic        r_d;
    logic        r_frame_valid;
    logic        r_sync_err;
    logic [7:0]  r_frame_cnt;

    // Alignment FSM, slot counter, shadow capture and frame commit, all in one registered process.
    // Slots 0..2 go into shadow bits and slot 3 commits all four bits together, so a..d always
    // hold one coherent frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= UNLOCKED;
            r_slot        <= 2'd0;
            r_sh_a        <= 1'b0;
            r_sh_b        <= 1'b0;
            r_sh_c        <= 1'b0;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
            r_c           <= 1'b0;
            r_d           <= 1'b0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (en) begin
                case (r_state)
                    UNLOCKED: begin
                        if (sync) begin
                            r_sh_a  <= din;
                            r_slot  <= 2'd1;
                            r_state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (sync) begin
                            // A sync outside slot 0 drops the partial frame and restarts at slot 0.
                            // Stale shadow b/c bits are overwritten before the next commit.
                            if (r_slot != 2'd0) begin
                                r_sync_err <= 1'b1;
                            end
                            r_sh_a <= din;
                            r_slot <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd0: begin
                                    r_sync_err <= 1'b1;
                                    r_state    <= UNLOCKED;
                                    r_slot     <= 2'd0;
                                end
                                2'd1: begin
                                    r_sh_b <= din;
                                    r_slot <= 2'd2;
                                end
                                2'd2: begin
                                    r_sh_c <= din;
                                    r_slot <= 2'd3;
                                end
                                default: begin
                                    r_a           <= r_sh_a;
                                    r_b           <= r_sh_b;
                                    r_c           <= r_sh_c;
                                    r_d           <= din;
                                    r_frame_valid <= 1'b1;
                                    r_frame_cnt   <= r_frame_cnt + 8'd1;
                                    r_slot        <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        r_state <= UNLOCKED;
                        r_slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign c           = r_c;
    assign d           = r_d;
    assign s1          = r_slot[1];
    assign s0          = r_slot[0];
    assign locked      = (r_state == LOCKED);
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_nand_tdm_demux.sv
// Bench for nand_tdm_demux: directed scenarios plus randomized strobes.
// Expected frame/error events are queued by a frame-level model and popped by an output monitor.
// Slot and lock status are compared against the model before each new stimulus cycle.
module tb_nand_tdm_demux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       din = 1'b0;
    logic       sync = 1'b0;
    logic       en = 1'b0;
    logic       a, b, c, d, s1, s0, locked, frame_valid, sync_err;
    logic [7:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         is_frame;
        logic [3:0] dat;
        logic [7:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    bit         m_bits[$];
    bit         m_locked = 1'b0;
    int         m_cnt = 0;
    logic [3:0] mon_out = 4'd0;

    nand_tdm_demux dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sync(sync), .en(en),
        .a(a), .b(b), .c(c), .d(d), .s1(s1), .s0(s0),
        .locked(locked), .frame_valid(frame_valid), .sync_err(sync_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level reference: a channel list that grows per strobe and is emitted at four entries.
    task automatic model_strobe(input bit di, input bit sy);
        ev_t e;
        if (!m_locked) begin
            if (sy) begin
                m_bits   = {di};
                m_locked = 1'b1;
            end
        end else if (sy) begin
            if (m_bits.size() != 0) begin
                e.is_frame = 1'b0; e.dat = 4'd0; e.cnt = m_cnt[7:0];
                exp_q.push_back(e);
            end
            m_bits = {di};
        end else if (m_bits.size() == 0) begin
            e.is_frame = 1'b0; e.dat = 4'd0; e.cnt = m_cnt[7:0];
            exp_q.push_back(e);
            m_locked = 1'b0;
        end else begin
            m_bits.push_back(di);
            if (m_bits.size() == 4) begin
                m_cnt = (m_cnt + 1) % 256;
                e.is_frame = 1'b1;
                e.dat = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
                e.cnt = m_cnt[7:0];
                exp_q.push_back(e);
                m_bits = {};
            end
        end
    endtask

    // One clock cycle of stimulus; first confirms lock/slot from all earlier strobes.
    task automatic cyc(input bit e, input bit di, input bit sy);
        int slot;
        logic [2:0] exp_st;
        @(posedge clk);
        #1;
        slot = m_locked ? m_bits.size() : 0;
        exp_st = {m_locked, slot[1:0]};
        check("lock_slot", {locked, s1, s0}, exp_st);
        en = e; din = di; sync = sy;
        if (e) model_strobe(di, sy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic send_frame(input logic [3:0] bits, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, bits[3-i], i == 0);
            if (gaps) cyc(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {a, b, c, d, s1, s0, locked, frame_valid, sync_err, frame_cnt}, 32'd0);
        check("rst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        m_bits = {}; m_locked = 1'b0; m_cnt = 0;
        en = 1'b0; sync = 1'b0; din = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expected event per frame_valid/sync_err pulse, checks a..d hold otherwise.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst_n) begin
            mon_out = 4'd0;
        end else if (frame_valid || sync_err) begin
            check("pulse_exclusive", {31'd0, frame_valid & sync_err}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got fv=%0b err=%0b expected no event at %0t",
                         frame_valid, sync_err, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {31'd0, frame_valid}, {31'd0, e.is_frame});
                check("frame_cnt", frame_cnt, e.cnt);
                if (e.is_frame) begin
                    check("abcd_frame", {a, b, c, d}, e.dat);
                    mon_out = e.dat;
                end else begin
                    check("abcd_on_err", {a, b, c, d}, mon_out);
                end
            end
        end else begin
            check("abcd_hold", {a, b, c, d}, mon_out);
        end
    end

    initial begin
        int pos;
        bit e, sy;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_state", {a, b, c, d, s1, s0, locked, frame_valid, sync_err, frame_cnt}, 32'd0);
        #10;
        rst_n = 1'b1;

        // Contiguous frames, back to back.
        send_frame(4'b1001, 1'b0);
        idle(1);
        check("dir_abcd1", {a, b, c, d}, 4'b1001);
        check("dir_cnt1", frame_cnt, 8'd1);
        send_frame(4'b0110, 1'b0);
        idle(1);
        check("dir_abcd2", {a, b, c, d}, 4'b0110);
        check("dir_cnt2", frame_cnt, 8'd2);

        // en toggling through a frame.
        send_frame(4'b1011, 1'b1);
        idle(1);
        check("dir_abcd_gaps", {a, b, c, d}, 4'b1011);

        // Early sync at slot 2, then a clean frame starting at that sync.
        cyc(1, 1, 1); cyc(1, 0, 0);
        cyc(1, 1, 1); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        idle(1);
        check("dir_abcd_resync", {a, b, c, d}, 4'b1100);
        check("dir_locked_resync", {31'd0, locked}, 32'd1);

        // Missing sync at slot 0 while locked, then ignored data, then relock.
        cyc(1, 1, 0);
        cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0);
        idle(1);
        check("dir_unlocked", {31'd0, locked}, 32'd0);
        check("dir_abcd_ignored", {a, b, c, d}, 4'b1100);
        send_frame(4'b0101, 1'b0);
        idle(1);
        check("dir_abcd_relock", {a, b, c, d}, 4'b0101);

        // Counter wrap after 256 frames from reset.
        do_reset();
        for (int i = 0; i < 255; i++) send_frame(4'($urandom), 1'b0);
        idle(1);
        check("dir_cnt_255", frame_cnt, 8'd255);
        send_frame(4'b1110, 1'b0);
        idle(1);
        check("dir_cnt_wrap", frame_cnt, 8'd0);

        // Randomized strobes with occasional sync misplacement.
        pos = 0;
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(3) != 0);
            sy = (pos == 0) ^ ($urandom_range(19) == 0);
            cyc(e, 1'($urandom), sy);
            if (e) pos = sy ? 1 : (pos + 1) % 4;
        end
        idle(2);

        // Reset mid-frame; capture only resumes from the next sync.
        send_frame(4'b0011, 1'b0);
        cyc(1, 1, 1); cyc(1, 1, 0);
        do_reset();
        cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
        send_frame(4'b1010, 1'b0);
        idle(2);
        check("dir_abcd_after_rst", {a, b, c, d}, 4'b1010);
        check("dir_cnt_after_rst", frame_cnt, 8'd1);

        idle(2);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
